// File: rtl/hybrid_adder_if.sv
// Operand/result bundle for the hybrid adder: operands and carry-in travel
// toward the adder, the registered result and its valid flag travel back.
interface hybrid_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, overflow, out_valid
  );
endinterface

// File: rtl/hybrid_adder.sv
// Hybrid adder: BLOCK-bit carry-lookahead blocks whose block carries ripple
// into the next block, with a one-cycle registered result and valid flag.
module hybrid_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic           clk,
  input  logic           rst,
  hybrid_adder_if.slave  bus
);

  localparam int NBLK = WIDTH / BLOCK;

  // Full lookahead inside one block: carry j+1 is the OR of every generate
  // propagated up to j, plus c0 propagated through the whole prefix.
  function automatic logic [BLOCK-1:0] cla_carries(
    input logic [BLOCK-1:0] g,
    input logic [BLOCK-1:0] p,
    input logic             c0
  );
    logic [BLOCK-1:0] c;
    logic             term;
    logic             acc;
    c = '0;
    for (int j = 0; j < BLOCK; j++) begin
      acc = c0;
      for (int k = 0; k <= j; k++) acc = acc & p[k];
      for (int k = 0; k <= j; k++) begin
        term = g[k];
        for (int m = k + 1; m <= j; m++) term = term & p[m];
        acc = acc | term;
      end
      c[j] = acc;
    end
    return c;
  endfunction

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign g        = bus.a & bus.b;
  assign p        = bus.a ^ bus.b;
  assign carry[0] = bus.cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    assign carry[i*BLOCK+1 +: BLOCK] =
      cla_carries(g[i*BLOCK +: BLOCK], p[i*BLOCK +: BLOCK], carry[i*BLOCK]);
  end

  assign sum_c  = p ^ carry[WIDTH-1:0];
  assign cout_c = carry[WIDTH];
  assign ovf_c  = carry[WIDTH-1] ^ carry[WIDTH];

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; the data path holds when in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum      <= sum_c;
        bus.cout     <= cout_c;
        bus.overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_hybrid_adder.sv
// Self-checking bench for hybrid_adder: directed and random operands, with
// expected results queued at drive time and popped when out_valid is seen.
module tb_hybrid_adder;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic clk;
  logic rst;

  hybrid_adder_if #(.WIDTH(WIDTH)) bus ();

  hybrid_adder #(.WIDTH(WIDTH), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  result_t exp_q[$];
  result_t held;
  int      checks;
  int      errors;

  function automatic result_t model(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic cin);
    result_t    r;
    logic [WIDTH:0] full;
    logic       c_msb;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    c_msb  = a[WIDTH-1] ^ b[WIDTH-1] ^ r.sum[WIDTH-1];
    r.ovf  = c_msb ^ r.cout;
    return r;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input result_t r,
                               input logic valid);
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, valid});
    check({tag, ".sum"},       bus.sum, r.sum);
    check({tag, ".cout"},      {31'd0, bus.cout}, {31'd0, r.cout});
    check({tag, ".overflow"},  {31'd0, bus.overflow}, {31'd0, r.ovf});
  endtask

  // One clock step: drive operands, take an edge, then compare 1 ns later.
  task automatic step(input string tag, input logic valid,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin);
    result_t r;
    bus.in_valid = valid;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    if (valid) exp_q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s.unexpected_valid: observed=1 expected=0", tag);
        return;
      end
      r    = exp_q.pop_front();
      held = r;
    end else begin
      r = held;
    end
    check_outputs(tag, r, valid);
  endtask

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  initial begin
    checks       = 0;
    errors       = 0;
    held         = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", '0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    step("idle0", 1'b0, '0, '0, 1'b0);
    step("idle1", 1'b0, '0, '0, 1'b0);

    step("add_4_8", 1'b1, 32'd4, 32'd8, 1'b0);
    check("add_4_8.value", bus.sum, 32'h0000_000C);
    step("add_hold", 1'b0, 32'd99, 32'd1, 1'b0);
    check("add_hold.value", bus.sum, 32'h0000_000C);

    step("chain_full", 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    check("chain_full.cout", {31'd0, bus.cout}, 32'd1);
    step("chain_blk01", 1'b1, 32'h0000_000F, 32'h0000_0001, 1'b0);
    check("chain_blk01.value", bus.sum, 32'h0000_0010);

    step("ovf_pos", 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("ovf_pos.value", bus.sum, 32'h8000_0000);
    check("ovf_pos.flag", {31'd0, bus.overflow}, 32'd1);
    step("ovf_neg", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("ovf_neg.flags", {30'd0, bus.cout, bus.overflow}, 32'd3);

    step("sub_10_3", 1'b1, 32'd10, ~32'd3, 1'b1);
    check("sub_10_3.value", bus.sum, 32'd7);
    step("sub_3_10", 1'b1, 32'd3, ~32'd10, 1'b1);
    check("sub_3_10.value", bus.sum, 32'hFFFF_FFF9);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom();
      rb = $urandom();
      step("random", ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)));
    end
    step("pre_reset", 1'b1, 32'hFFFF_FFF0, 32'h0000_0003, 1'b0);

    // Pending capture is thrown away by an asynchronous reset between edges.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'h1234_5678;
    bus.b        = 32'h1111_1111;
    bus.cin      = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", '0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_held", '0, 1'b0);
    held = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
    check("post_rst.value", bus.sum, 32'h2345_6789);
    step("post_idle", 1'b0, '0, '0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hybrid_adder.md
Name: hybrid_adder

Overview:
- 32-bit hybrid adder for the KGP-RISC ALU datapath.
- Internally the word is split into 4-bit carry-lookahead (CLA) blocks. The carry ripples from block to block.
- The combinational sum and carry-out are captured in an output register, giving a 1-cycle registered result with a valid flag.
- The ALU uses it for add/sub and for address arithmetic.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, CLA block width in bits; number of blocks = WIDTH/BLOCK (8 by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle; the result is captured when high.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered a + b + cin, low WIDTH bits.
- cout  output  1  registered carry out of the MSB.
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  high for one cycle per captured result.

Behaviour:
- Reset:
  - When rst is high (asynchronous assert), sum=0, cout=0, overflow=0 and out_valid=0 immediately.
  - Outputs hold these values while rst is high.
  - Deassertion takes effect at the next clk edge.
- CLA block i (bits 4i..4i+3):
  - g_j = a_j & b_j and p_j = a_j ^ b_j.
  - Internal carries use full lookahead:
    - c1 = g0 | p0·c0
    - c2 = g1 | p1·g0 | p1·p0·c0
    - c3 and c4 follow the same expansion.
  - Block sum bit s_j = p_j ^ c_j.
- Inter-block chaining:
  - c0 of block 0 = cin.
  - c0 of block i = c4 of block i-1 (ripple).
  - cout = c4 of the last block.
- overflow = carry into bit WIDTH-1 XOR cout.
- Combinational result (sum_c, cout_c, ovf_c) is a pure function of a, b and cin. It has no dependence on state.
- Latency: exactly 1 cycle. If in_valid is high at rising edge k, then sum/cout/overflow take the result of that edge's inputs and out_valid=1 after edge k.
- If in_valid is low at an edge: sum/cout/overflow hold their previous values and out_valid=0.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs, with no bubbles.
- Arithmetic wraps modulo 2^WIDTH. The carry is reported only on cout; no saturation.
- Subtraction is done by the caller (b inverted, cin=1). The adder gives no special treatment to it.
- Reset mid-operation:
  - A result pending capture at the reset edge is discarded.
  - The first valid result after reset release appears one cycle after the first in_valid edge.
- No X propagation from unused blocks: every bit of sum is driven.

Test Plan:
- Reset: assert rst with a=b=cin=0, then release and hold in_valid=0 → sum=0, cout=0, overflow=0, out_valid=0 throughout.
- Basic add: a=4, b=8, cin=0, in_valid=1 for one edge → next cycle sum=12 (0x0000000C), cout=0, overflow=0, out_valid=1. The cycle after that, out_valid=0 and sum stays 12.
- Full carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1, overflow=0. Also a=0x0000000F, b=0x00000001, cin=0 → sum=0x00000010; this checks the block-0 to block-1 carry.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, overflow=1. Also a=0x80000000, b=0x80000000 → sum=0, cout=1, overflow=1.
- Subtraction pattern and pipelining: apply back-to-back edges:
  - 10 + ~3 + 1 → sum=7, cout=1.
  - 3 + ~10 + 1 → sum=0xFFFFFFF9, cout=0.
  - Expected: results appear on consecutive cycles, each with out_valid=1.
- Async reset mid-stream: in_valid=1 with a=0x12345678, b=0x11111111; assert rst between clock edges → outputs go to 0 immediately, without waiting for clk. After release with in_valid=1 on the same operands → sum=0x23456789 one cycle later.
